if_stage: RTL and testbench

Instruction fetch stage of the RV32I pipeline, directly upstream of the decoder. Holds the PC, issues word-aligned fetch requests to instruction memory over a valid/ready interface, absorbs in-order responses into a 2-entry buffer, and presents `{pc, instr}` to decode over a valid/ready handshake. Supports redirects from later stages, discarding stale in-flight responses.

---
 rtl/if_stage_pkg.sv | 43 ++++
 rtl/if_stage_if.sv | 37 +++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/if_stage.sv | 101 ++++++++++
 tb/tb_if_stage.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared RV32I pipeline package: data width, opcode encodings, the fetch entry
// carried from fetch to decode, the default reset PC and a word-align helper.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [6:0] {
    OpLoad    = 7'b0000011,
    OpMiscMem = 7'b0001111,
    OpImm     = 7'b0010011,
    OpAuipc   = 7'b0010111,
    OpStore   = 7'b0100011,
    OpReg     = 7'b0110011,
    OpLui     = 7'b0110111,
    OpBranch  = 7'b1100011,
    OpJalr    = 7'b1100111,
    OpJal     = 7'b1101111,
    OpSystem  = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3AddSub = 3'b000,
    F3Sll    = 3'b001,
    F3Slt    = 3'b010,
    F3Sltu   = 3'b011,
    F3Xor    = 3'b100,
    F3SrlSra = 3'b101,
    F3Or     = 3'b110,
    F3And    = 3'b111
  } funct3_alu_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's handshake buses: instruction-memory request and
// response, redirect from later stages, and the decode-bound entry.
//   master : the fetch stage (drives requests and the decode entry)
//   slave  : the environment (memory, redirect source, decoder)
interface if_stage_if;
  import if_stage_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            id_illegal;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_pc, id_instr, id_illegal,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_pc, id_instr, id_illegal,
    output id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetch entries with flush.
//   push_i/data_i : write an entry (ignored when full unless popping too)
//   pop_i         : drop the head (ignored when empty)
//   flush_i       : empty the FIFO; overrides push and pop
//   head_o        : current head entry; count_o : occupancy 0..2
module fetch_fifo
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // When full, a simultaneous pop frees the slot being written.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push && !do_pop)      cnt_d = cnt_q + 2'd1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch stage. Issues word-aligned fetches under a two-slot
// credit (outstanding + buffered), tags each accepted request with its PC,
// buffers in-order responses and presents {pc, instr} to decode. A redirect
// flushes buffered state and discards responses still in flight.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus_io     : memory request/response, redirect and decode handshakes
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus_io
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      out_cnt_q, out_cnt_d;
  logic [1:0]      drop_cnt_q, drop_cnt_d;
  logic [1:0]      fifo_cnt, tag_cnt;
  fetch_entry_t    fifo_head, fifo_wdata, tag_head, tag_wdata;
  logic            redirect, req_fire, rsp_fire, rsp_keep, id_fire;
  logic            unused_tag;

  assign redirect = bus_io.redirect_valid;

  assign bus_io.imem_req_valid = rst_n && !redirect &&
                                 (({1'b0, out_cnt_q} + {1'b0, fifo_cnt}) < 3'd2);
  assign bus_io.imem_req_addr  = pc_q;

  assign req_fire = bus_io.imem_req_valid && bus_io.imem_req_ready;
  // A response with nothing outstanding is a protocol violation and ignored.
  assign rsp_fire = bus_io.imem_rsp_valid && (out_cnt_q != 2'd0);
  assign rsp_keep = rsp_fire && !redirect && (drop_cnt_q == 2'd0);
  assign id_fire  = bus_io.id_valid && bus_io.id_ready;

  assign tag_wdata  = '{pc: pc_q, instr: '0};
  assign fifo_wdata = '{pc: tag_head.pc, instr: bus_io.imem_rsp_data};

  // Tag queue only holds requests whose responses will be kept, so it is
  // popped by kept responses only and flushed together with the FIFO.
  fetch_fifo u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_fire),
    .data_i  (tag_wdata),
    .pop_i   (rsp_keep),
    .flush_i (redirect),
    .head_o  (tag_head),
    .count_o (tag_cnt)
  );

  fetch_fifo u_out_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_keep),
    .data_i  (fifo_wdata),
    .pop_i   (id_fire),
    .flush_i (redirect),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign unused_tag = ^{tag_head.instr, tag_cnt};

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (req_fire && !rsp_fire)      out_cnt_d = out_cnt_q + 2'd1;
    else if (!req_fire && rsp_fire) out_cnt_d = out_cnt_q - 2'd1;

    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      // Everything still in flight is stale; a same-cycle response is consumed now.
      drop_cnt_d = rsp_fire ? (out_cnt_q - 2'd1) : out_cnt_q;
    end else if (rsp_fire && (drop_cnt_q != 2'd0)) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end

    pc_d = pc_q;
    if (redirect)      pc_d = word_align(bus_io.redirect_pc);
    else if (req_fire) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus_io.id_valid   = (fifo_cnt != 2'd0);
  assign bus_io.id_pc      = fifo_head.pc;
  assign bus_io.id_instr   = fifo_head.instr;
  assign bus_io.id_illegal = bus_io.id_valid && (fifo_head.instr[1:0] != 2'b11);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: queues of buffered entries and request PCs, plain counters.
  fetch_entry_t m_fifo[$];
  logic [31:0]  m_tags[$];
  int           m_out, m_drop;
  logic [31:0]  m_pc;

  // Memory model: in-order pending responses with due cycle.
  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;
  pend_t pend[$];
  int    last_due;

  // Stimulus knobs.
  int          lat_min = 1, lat_max = 1;
  int          req_ready_pct = 100, id_ready_pct = 100, redir_pct = 0;
  bit          force_redir = 0, force_on_rsp = 0;
  logic [31:0] force_rpc = '0;
  bit          force_data_en = 0;
  logic [31:0] force_data = '0;

  // Outputs sampled at the falling edge of the last stepped cycle.
  logic        s_req_valid, s_id_valid, s_id_illegal;
  logic [31:0] s_addr, s_id_pc, s_id_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_tags.delete();
    m_out    = 0;
    m_drop   = 0;
    m_pc     = 32'h0000_0000;
    pend.delete();
    last_due = 0;
  endtask

  function automatic logic [31:0] gen_data();
    logic [31:0] d;
    if (force_data_en) return force_data;
    d = $urandom;
    if ($urandom_range(3) != 0) d[1:0] = 2'b11;
    return d;
  endfunction

  // Called just after a rising edge: apply this cycle's inputs.
  task automatic drive_inputs();
    logic [31:0] r;
    bus.imem_req_ready = ($urandom_range(99) < req_ready_pct);
    bus.id_ready       = ($urandom_range(99) < id_ready_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    if (force_redir && (!force_on_rsp || bus.imem_rsp_valid)) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = force_rpc;
      force_redir        = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      r = $urandom;
      if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = r;
    end else begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = $urandom;
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step();
    bit          exp_rv, exp_idv, exp_ill, rf, rsf, idf;
    pend_t       p;
    fetch_entry_t e;
    drive_inputs();
    @(negedge clk);
    s_req_valid  = bus.imem_req_valid;
    s_addr       = bus.imem_req_addr;
    s_id_valid   = bus.id_valid;
    s_id_pc      = bus.id_pc;
    s_id_instr   = bus.id_instr;
    s_id_illegal = bus.id_illegal;
    if (!rst_n) begin
      check("rst_req_valid", s_req_valid, 0);
      check("rst_id_valid", s_id_valid, 0);
      check("rst_id_pc", s_id_pc, 0);
      check("rst_id_instr", s_id_instr, 0);
      check("rst_id_illegal", s_id_illegal, 0);
      model_reset();
    end else begin
      exp_rv  = !bus.redirect_valid && (m_out + m_fifo.size() < 2);
      exp_idv = (m_fifo.size() != 0);
      exp_ill = exp_idv && (m_fifo[0].instr[1:0] != 2'b11);
      check("req_valid", s_req_valid, exp_rv);
      if (exp_rv) check("req_addr", s_addr, m_pc);
      check("id_valid", s_id_valid, exp_idv);
      if (exp_idv) begin
        check("id_pc", s_id_pc, m_fifo[0].pc);
        check("id_instr", s_id_instr, m_fifo[0].instr);
      end
      check("id_illegal", s_id_illegal, exp_ill);

      rf  = exp_rv && bus.imem_req_ready;
      rsf = bus.imem_rsp_valid && (m_out > 0);
      idf = exp_idv && bus.id_ready;
      if (rf) begin
        p.due = cyc + $urandom_range(lat_max, lat_min);
        if (p.due <= last_due) p.due = last_due + 1;
        last_due = p.due;
        p.data   = gen_data();
        pend.push_back(p);
      end
      if (bus.redirect_valid) begin
        m_fifo.delete();
        m_tags.delete();
        m_drop = m_out - (rsf ? 1 : 0);
        m_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (idf) void'(m_fifo.pop_front());
        if (rsf) begin
          if (m_drop > 0) m_drop--;
          else if (m_tags.size() > 0) begin
            e.pc    = m_tags.pop_front();
            e.instr = bus.imem_rsp_data;
            m_fifo.push_back(e);
          end
        end
        if (rf) begin
          m_tags.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      m_out = m_out + (rf ? 1 : 0) - (rsf ? 1 : 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_id(input string name);
    for (int n = 0; n < 40; n++) begin
      step();
      if (s_id_valid) return;
    end
    timeout(name);
  endtask

  task automatic wait_req(input string name);
    for (int n = 0; n < 40; n++) begin
      step();
      if (s_req_valid) return;
    end
    timeout(name);
  endtask

  task automatic do_redirect(input logic [31:0] rpc, input bit on_rsp);
    force_rpc    = rpc;
    force_on_rsp = on_rsp;
    force_redir  = 1;
    for (int n = 0; n < 40 && force_redir; n++) step();
    if (force_redir) begin
      force_redir = 0;
      timeout("redirect_apply");
    end
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) step();

    // Reset release, L=1, decoder always ready.
    rst_n = 1'b1;
    step();
    check("first_req_valid", s_req_valid, 1);
    check("first_req_addr", s_addr, 32'h0);
    step();
    check("c2_id_valid", s_id_valid, 0);
    check("c2_req_addr", s_addr, 32'h4);
    step();
    check("c3_id_valid", s_id_valid, 1);
    check("c3_id_pc", s_id_pc, 32'h0);
    step();
    check("c4_id_pc", s_id_pc, 32'h4);
    check("c4_req_addr", s_addr, 32'h8);

    // Decoder stall: credit fills, head held.
    id_ready_pct = 0;
    repeat (5) step();
    check("stall_req_valid", s_req_valid, 0);
    check("stall_id_valid", s_id_valid, 1);
    check("stall_id_pc", s_id_pc, 32'h8);
    id_ready_pct = 100;
    repeat (6) step();

    // L=3 with two requests in flight, redirect to 0x100.
    lat_min = 3;
    lat_max = 3;
    for (int n = 0; n < 20 && m_out != 2; n++) step();
    check("two_in_flight", m_out, 2);
    do_redirect(32'h100, 0);
    step();
    check("redir_flush_id_valid", s_id_valid, 0);
    wait_id("redir_0x100");
    check("redir_id_pc", s_id_pc, 32'h100);

    // Redirect coinciding with a response, unaligned target.
    lat_min = 1;
    lat_max = 1;
    do_redirect(32'h203, 1);
    wait_req("redir_0x203_req");
    check("redir_203_addr", s_addr, 32'h200);
    wait_id("redir_0x203_id");
    check("redir_203_id_pc", s_id_pc, 32'h200);

    // Non-32-bit encoding is flagged; a normal ADDI is not.
    force_data_en = 1;
    force_data    = 32'h0000_0001;
    do_redirect(32'h40, 0);
    wait_id("illegal_id");
    check("illegal_instr", s_id_instr, 32'h1);
    check("illegal_flag", s_id_illegal, 1);
    force_data = 32'h0000_0013;
    do_redirect(32'h80, 0);
    wait_id("legal_id");
    check("legal_pc", s_id_pc, 32'h80);
    check("legal_flag", s_id_illegal, 0);
    force_data_en = 0;

    // PC wrap.
    do_redirect(32'hFFFF_FFFC, 0);
    wait_req("wrap_req0");
    check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    wait_req("wrap_req1");
    check("wrap_addr1", s_addr, 32'h0);
    wait_id("wrap_id");
    check("wrap_id_pc", s_id_pc, 32'hFFFF_FFFC);

    // Randomised traffic.
    lat_min       = 1;
    lat_max       = 4;
    req_ready_pct = 70;
    id_ready_pct  = 60;
    redir_pct     = 4;
    repeat (3000) step();

    // Asynchronous reset mid-stream.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_req_valid", bus.imem_req_valid, 0);
    check("async_id_valid", bus.id_valid, 0);
    check("async_id_pc", bus.id_pc, 0);
    check("async_id_instr", bus.id_instr, 0);
    check("async_id_illegal", bus.id_illegal, 0);
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("post_rst_addr", s_addr, 32'h0);
    repeat (500) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
